// File: rtl/frogger_pkg.sv
// frogger_pkg: shared game-flow and sound enums for the Frogger UI path.
package frogger_pkg;
   typedef enum logic [1:0] {MENU, PLAYING, DEAD, WIN} state_t;
   typedef enum logic [1:0] {UI_PRESS, NEXTLEVEL, CRASH, CELEBRATION} sound_t;
   localparam logic [7:0] ASCII_ZERO = 8'h30;
   function automatic logic [23:0] bcd_to_ascii(input logic [11:0] b);
      return {ASCII_ZERO + {4'h0, b[11:8]}, ASCII_ZERO + {4'h0, b[7:4]}, ASCII_ZERO + {4'h0, b[3:0]}};
   endfunction
endpackage

// File: rtl/game_flow_ctrl_if.sv
// game_flow_ctrl_if: sound-request valid/ready handshake to the audio block.
interface game_flow_ctrl_if;
   import frogger_pkg::*;
   logic   sound_valid;
   sound_t sound_id;
   logic   sound_ready;
   modport master (output sound_valid, sound_id, input sound_ready);
   modport slave  (input sound_valid, sound_id, output sound_ready);
endinterface

// File: rtl/bcd_score3.sv
// bcd_score3: 3-digit BCD score register with clear, +1, +10, saturating at 999.
module bcd_score3 (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        add1,
   input  logic        add10,
   output logic [11:0] bcd
);
   logic [3:0] h_q, t_q, o_q, h_d, t_d, o_d;
   logic       t_inc, h_inc;
   always_comb begin
      t_inc = add10 | (add1 & (o_q == 4'd9));
      h_inc = t_inc & (t_q == 4'd9);
      o_d = add1 ? ((o_q == 4'd9) ? 4'd0 : o_q + 4'd1) : o_q;
      t_d = t_inc ? ((t_q == 4'd9) ? 4'd0 : t_q + 4'd1) : t_q;
      h_d = h_inc ? h_q + 4'd1 : h_q;
      // a carry out of the hundreds digit means the true sum passed 999
      if (h_inc && h_q == 4'd9) {h_d, t_d, o_d} = 12'h999;
      if (clr) {h_d, t_d, o_d} = 12'h000;
   end
   always_ff @(posedge clk) begin
      if (reset) {h_q, t_q, o_q} <= 12'h000;
      else {h_q, t_q, o_q} <= {h_d, t_d, o_d};
   end
   assign bcd = {h_q, t_q, o_q};
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: MENU/PLAYING/DEAD/WIN sequencer with BCD score, level count
// and a two-slot prioritised sound request queue.
module game_flow_ctrl
   import frogger_pkg::*;
#(
   parameter int MAX_LEVEL   = 5,
   parameter int HOLD_FRAMES = 120
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_tick,
   input  logic              key_press,
   input  logic              hop_fwd,
   input  logic              reached_goal,
   input  logic              collision,
   output state_t            state,
   output logic [11:0]       score_bcd,
   output logic [23:0]       score_ascii,
   output logic [2:0]        level,
   game_flow_ctrl_if.master  snd
);
   localparam logic [2:0] MAX_L = 3'(MAX_LEVEL);
   localparam logic [9:0] HOLD  = 10'(HOLD_FRAMES);
   state_t     state_q, state_d;
   logic [2:0] level_q, level_d;
   logic [9:0] hold_q, hold_d;
   logic       ov_q, ov_d, pv_q, pv_d;
   sound_t     oid_q, oid_d, pid_q, pid_d;
   logic       req, clr, add1, add10, accept;
   sound_t     req_id;
   bcd_score3 u_score (
      .clk(clk), .reset(reset), .clr(clr), .add1(add1), .add10(add10), .bcd(score_bcd)
   );
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      hold_d  = hold_q;
      req     = 1'b0;
      req_id  = UI_PRESS;
      clr     = 1'b0;
      add1    = 1'b0;
      add10   = 1'b0;
      case (state_q)
         MENU: if (key_press) begin
            state_d = PLAYING;
            level_d = 3'd1;
            clr     = 1'b1;
            req     = 1'b1;
         end
         PLAYING: if (collision) begin
            state_d = DEAD;
            hold_d  = HOLD;
            req     = 1'b1;
            req_id  = CRASH;
         end else if (reached_goal) begin
            add10 = 1'b1;
            req   = 1'b1;
            if (level_q == MAX_L) begin
               state_d = WIN;
               hold_d  = HOLD;
               req_id  = CELEBRATION;
            end else begin
               level_d = level_q + 3'd1;
               req_id  = NEXTLEVEL;
            end
         end else add1 = hop_fwd;
         default: if (hold_q != 10'd0) hold_d = frame_tick ? hold_q - 10'd1 : hold_q;
         else if (key_press) begin
            state_d = MENU;
            req     = 1'b1;
         end
      endcase
   end
   // pending only ever holds a request while the output slot is occupied
   always_comb begin
      accept = ov_q & snd.sound_ready;
      ov_d   = ov_q;
      oid_d  = oid_q;
      pv_d   = pv_q;
      pid_d  = pid_q;
      if (accept) begin
         ov_d  = pv_q | req;
         oid_d = pv_q ? pid_q : (req ? req_id : oid_q);
         pv_d  = pv_q & req;
         pid_d = (pv_q & req) ? req_id : pid_q;
      end else if (!ov_q) begin
         ov_d  = req;
         oid_d = req ? req_id : oid_q;
      end else if (req && (!pv_q || req_id > pid_q)) begin
         pv_d  = 1'b1;
         pid_d = req_id;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MENU;
         level_q <= 3'd1;
         hold_q  <= 10'd0;
         ov_q    <= 1'b0;
         oid_q   <= UI_PRESS;
         pv_q    <= 1'b0;
         pid_q   <= UI_PRESS;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         hold_q  <= hold_d;
         ov_q    <= ov_d;
         oid_q   <= oid_d;
         pv_q    <= pv_d;
         pid_q   <= pid_d;
      end
   end
   assign state           = state_q;
   assign level           = level_q;
   assign score_ascii     = bcd_to_ascii(score_bcd);
   assign snd.sound_valid = ov_q;
   assign snd.sound_id    = oid_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed checks of two game_flow_ctrl instances
// (default parameters, and MAX_LEVEL=2/HOLD_FRAMES=3).
module tb_game_flow_ctrl;
   import frogger_pkg::*;
   logic clk = 1'b0, reset = 1'b0, frame_tick = 1'b0, key_press = 1'b0;
   logic hop_fwd = 1'b0, reached_goal = 1'b0, collision = 1'b0, ready = 1'b1;
   state_t      st1, st2;
   logic [11:0] bcd1, bcd2;
   logic [23:0] asc1, asc2;
   logic [2:0]  lvl1, lvl2;
   int n_chk = 0, n_pass = 0;
   game_flow_ctrl_if sif1();
   game_flow_ctrl_if sif2();
   assign sif1.sound_ready = ready;
   assign sif2.sound_ready = ready;
   game_flow_ctrl dut1 (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .key_press(key_press),
      .hop_fwd(hop_fwd), .reached_goal(reached_goal), .collision(collision),
      .state(st1), .score_bcd(bcd1), .score_ascii(asc1), .level(lvl1), .snd(sif1)
   );
   game_flow_ctrl #(.MAX_LEVEL(2), .HOLD_FRAMES(3)) dut2 (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .key_press(key_press),
      .hop_fwd(hop_fwd), .reached_goal(reached_goal), .collision(collision),
      .state(st2), .score_bcd(bcd2), .score_ascii(asc2), .level(lvl2), .snd(sif2)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
      {reset, frame_tick, key_press, hop_fwd, reached_goal, collision} = '0;
   endtask
   initial begin
      reset = 1'b1;
      step();
      check("rst_state", st1, 0);
      check("rst_score", bcd1, 12'h000);
      check("rst_ascii", asc1, 24'h303030);
      check("rst_level", lvl1, 1);
      check("rst_valid", sif1.sound_valid, 0);
      check("rst_id", sif1.sound_id, 0);
      key_press = 1'b1; step();
      check("start_state", st1, 1);
      check("start_ascii", asc1, 24'h303030);
      check("start_level", lvl1, 1);
      check("start_valid", sif1.sound_valid, 1);
      check("start_id", sif1.sound_id, 0);
      ready = 1'b0;
      repeat (5) step();
      check("stall_valid", sif1.sound_valid, 1);
      check("stall_id", sif1.sound_id, 0);
      ready = 1'b1; step();
      check("drain_valid", sif1.sound_valid, 0);
      repeat (9) begin hop_fwd = 1'b1; step(); end
      reached_goal = 1'b1; step();
      check("goal_score", bcd1, 12'h019);
      check("goal_ascii", asc1, 24'h303139);
      check("goal_level", lvl1, 2);
      check("goal_id", sif1.sound_id, 1);
      check("goal_valid", sif1.sound_valid, 1);
      repeat (976) begin hop_fwd = 1'b1; step(); end
      check("hop995", bcd1, 12'h995);
      reached_goal = 1'b1; step();
      check("sat_goal", bcd1, 12'h999);
      check("sat_level", lvl1, 3);
      hop_fwd = 1'b1; step();
      check("sat_hop", bcd1, 12'h999);
      check("sat_ascii", asc1, 24'h393939);
      reset = 1'b1; step();
      key_press = 1'b1; step();
      step();
      repeat (42) begin hop_fwd = 1'b1; step(); end
      check("pre_coll", bcd1, 12'h042);
      {collision, reached_goal, hop_fwd} = 3'b111; step();
      check("coll_state", st1, 2);
      check("coll_score", bcd1, 12'h042);
      check("coll_level", lvl1, 1);
      check("coll_id", sif1.sound_id, 2);
      key_press = 1'b1; step();
      check("dead_key", st1, 2);
      reset = 1'b1; step();
      key_press = 1'b1; step();
      reached_goal = 1'b1; step();
      check("w_level", lvl2, 2);
      check("w_id1", sif2.sound_id, 1);
      reached_goal = 1'b1; frame_tick = 1'b1; step();
      check("win_state", st2, 3);
      check("win_score", bcd2, 12'h020);
      check("win_id", sif2.sound_id, 3);
      frame_tick = 1'b1; step();
      frame_tick = 1'b1; step();
      key_press = 1'b1; step();
      check("win_key_early", st2, 3);
      frame_tick = 1'b1; key_press = 1'b1; step();
      check("win_key_tick", st2, 3);
      key_press = 1'b1; step();
      check("win_exit", st2, 0);
      check("win_exit_id", sif2.sound_id, 0);
      check("win_exit_valid", sif2.sound_valid, 1);
      check("menu_score", bcd2, 12'h020);
      reset = 1'b1; step();
      key_press = 1'b1; step();
      step();
      ready = 1'b0;
      reached_goal = 1'b1; step();
      check("q_out_next", sif2.sound_id, 1);
      collision = 1'b1; step();
      check("q_dead", st2, 2);
      check("q_hold_id", sif2.sound_id, 1);
      repeat (3) begin frame_tick = 1'b1; step(); end
      key_press = 1'b1; step();
      check("q_menu", st2, 0);
      check("q_still_next", sif2.sound_id, 1);
      ready = 1'b1; step();
      check("q_crash_valid", sif2.sound_valid, 1);
      check("q_crash_id", sif2.sound_id, 2);
      step();
      check("q_empty", sif2.sound_valid, 0);
      ready = 1'b0;
      key_press = 1'b1; step();
      collision = 1'b1; step();
      check("r_dead", st2, 2);
      reset = 1'b1; step();
      check("r_state", st2, 0);
      check("r_score", bcd2, 12'h000);
      check("r_ascii", asc2, 24'h303030);
      check("r_level", lvl2, 1);
      check("r_valid", sif2.sound_valid, 0);
      check("r_id", sif2.sound_id, 0);
      ready = 1'b1; step();
      check("r_no_pend", sif2.sound_valid, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
